parking_gate_arbiter: RTL and testbench

PARKING_GATE_ARBITER -- requirements
Module: parking_gate_arbiter

---
 rtl/parking_pkg.sv | 21 ++
 rtl/gate_timer.sv | 43 ++++
 rtl/parking_gate_arbiter.sv | 135 +++++++++++++
 tb/tb_parking_gate_arbiter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared state encoding and direction constants for the parking gate arbiter
package parking_pkg;

  // Controller states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_OPEN_IN  = 2'd1,
    ST_OPEN_OUT = 2'd2,
    ST_COOLDOWN = 2'd3
  } state_e;

  // Direction of the most recent grant, used for round-robin tie breaking.
  typedef enum logic {
    DIR_ENTRY = 1'b0,
    DIR_EXIT  = 1'b1
  } dir_e;

  // Width of the open-period timer.
  localparam int TIMER_W = 8;

endpackage

// File: rtl/gate_timer.sv
// rtl/gate_timer.sv - loadable down-counter with done flag that times the barrier open period
// Ports:
//   clk      - clock, all state changes on rising edge
//   rst      - synchronous reset, active-high (counter cleared to 0)
//   load     - load load_val this edge (wins over counting)
//   load_val - value to load
//   done     - high while the counter is 0
module gate_timer
  import parking_pkg::*;
#(
  parameter int WIDTH = TIMER_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Counts down to zero and parks there until reloaded.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/parking_gate_arbiter.sv
// rtl/parking_gate_arbiter.sv - arbitrates entry/exit requests onto one shared barrier and tracks occupancy
// Ports:
//   CLK       - clock, all state changes on rising edge
//   RST       - synchronous reset, active-high, priority over requests
//   Entry_Req - entry request level, held until Entry_Ack
//   Exit_Req  - exit request level, held until Exit_Ack
//   Entry_Ack - one-cycle grant pulse to entry requester
//   Exit_Ack  - one-cycle grant pulse to exit requester
//   Deny      - registered, high after an IDLE cycle with only ineligible requests
//   Gate_Open - barrier drive, high OPEN_CYCLES cycles per grant
//   Full      - Count equals CAPACITY
//   Count     - current occupancy
module parking_gate_arbiter
  import parking_pkg::*;
#(
  parameter int CAPACITY    = 6,
  parameter int OPEN_CYCLES = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Entry_Req,
  input  logic       Exit_Req,
  output logic       Entry_Ack,
  output logic       Exit_Ack,
  output logic       Deny,
  output logic       Gate_Open,
  output logic       Full,
  output logic [2:0] Count
);

  localparam logic [2:0]         CAP_W    = 3'(CAPACITY);
  // The grant edge is the first open cycle, so the timer expires on the last one.
  localparam logic [TIMER_W-1:0] OPEN_LD  = TIMER_W'(OPEN_CYCLES - 1);

  state_e     state_q, state_d;
  dir_e       last_dir_q, last_dir_d;
  logic [2:0] count_q, count_d;
  logic       entry_ack_q, entry_ack_d;
  logic       exit_ack_q, exit_ack_d;
  logic       deny_q, deny_d;
  logic       gate_open_q, gate_open_d;

  logic       entry_ok;
  logic       exit_ok;
  logic       timer_load;
  logic       timer_done;

  gate_timer #(
    .WIDTH(TIMER_W)
  ) u_gate_timer (
    .clk     (CLK),
    .rst     (RST),
    .load    (timer_load),
    .load_val(OPEN_LD),
    .done    (timer_done)
  );

  always_comb begin
    state_d     = state_q;
    last_dir_d  = last_dir_q;
    count_d     = count_q;
    entry_ack_d = 1'b0;
    exit_ack_d  = 1'b0;
    deny_d      = 1'b0;
    gate_open_d = 1'b0;
    timer_load  = 1'b0;

    entry_ok = Entry_Req && (count_q < CAP_W);
    exit_ok  = Exit_Req && (count_q != 3'd0);

    case (state_q)
      ST_IDLE: begin
        // Entry wins when alone, or on a tie if the last grant was an exit.
        if (entry_ok && (!exit_ok || (last_dir_q == DIR_EXIT))) begin
          state_d     = ST_OPEN_IN;
          last_dir_d  = DIR_ENTRY;
          count_d     = count_q + 3'd1;
          entry_ack_d = 1'b1;
          gate_open_d = 1'b1;
          timer_load  = 1'b1;
        end else if (exit_ok) begin
          state_d     = ST_OPEN_OUT;
          last_dir_d  = DIR_EXIT;
          count_d     = count_q - 3'd1;
          exit_ack_d  = 1'b1;
          gate_open_d = 1'b1;
          timer_load  = 1'b1;
        end else if (Entry_Req || Exit_Req) begin
          deny_d = 1'b1;
        end
      end
      ST_OPEN_IN, ST_OPEN_OUT: begin
        if (timer_done) begin
          state_d = ST_COOLDOWN;
        end else begin
          gate_open_d = 1'b1;
        end
      end
      ST_COOLDOWN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      last_dir_q  <= DIR_EXIT;
      count_q     <= 3'd0;
      entry_ack_q <= 1'b0;
      exit_ack_q  <= 1'b0;
      deny_q      <= 1'b0;
      gate_open_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_dir_q  <= last_dir_d;
      count_q     <= count_d;
      entry_ack_q <= entry_ack_d;
      exit_ack_q  <= exit_ack_d;
      deny_q      <= deny_d;
      gate_open_q <= gate_open_d;
    end
  end

  assign Entry_Ack = entry_ack_q;
  assign Exit_Ack  = exit_ack_q;
  assign Deny      = deny_q;
  assign Gate_Open = gate_open_q;
  assign Count     = count_q;
  assign Full      = (count_q == CAP_W);

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// tb/tb_parking_gate_arbiter.sv - directed table-driven bench for parking_gate_arbiter
module tb_parking_gate_arbiter;

  localparam int CAP = 2;
  localparam int OC  = 3;

  logic       CLK = 1'b0;
  logic       RST;
  logic       Entry_Req;
  logic       Exit_Req;
  logic       Entry_Ack;
  logic       Exit_Ack;
  logic       Deny;
  logic       Gate_Open;
  logic       Full;
  logic [2:0] Count;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  parking_gate_arbiter #(
    .CAPACITY   (CAP),
    .OPEN_CYCLES(OC)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .Entry_Req(Entry_Req),
    .Exit_Req (Exit_Req),
    .Entry_Ack(Entry_Ack),
    .Exit_Ack (Exit_Ack),
    .Deny     (Deny),
    .Gate_Open(Gate_Open),
    .Full     (Full),
    .Count    (Count)
  );

  // One row per clock: inputs held over the edge, outputs expected just after it.
  typedef struct {
    logic       rst, en, ex;
    logic       ea, xa, dn, go, fu;
    logic [2:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic en, input logic ex,
                              input logic ea, input logic xa, input logic dn,
                              input logic go, input logic fu, input int cnt);
    vec_t r;
    r.rst = rst; r.en = en; r.ex = ex;
    r.ea = ea; r.xa = xa; r.dn = dn; r.go = go; r.fu = fu;
    r.cnt = 3'(cnt);
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic x);
    RST = r; Entry_Req = e; Exit_Req = x;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic ea, input logic xa, input logic dn,
                         input logic go, input logic fu, input int cnt);
    chk({tag, " entry_ack"}, int'(Entry_Ack), int'(ea));
    chk({tag, " exit_ack"},  int'(Exit_Ack),  int'(xa));
    chk({tag, " deny"},      int'(Deny),      int'(dn));
    chk({tag, " gate_open"}, int'(Gate_Open), int'(go));
    chk({tag, " full"},      int'(Full),      int'(fu));
    chk({tag, " count"},     int'(Count),     cnt);
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0);
  endtask

  int ea_cyc, xa_cyc, ea_cnt, xa_cnt;

  initial begin
    RST = 1'b1; Entry_Req = 1'b0; Exit_Req = 1'b0;

    //                rst en ex   ea xa dn go fu cnt
    // Reset state.
    vecs.push_back(mk(1, 0, 0,   0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1,   0, 0, 0, 0, 0, 0));  // reset beats requests
    // Single entry: ack cycle 1 only, gate 1-3, cooldown 4, idle 5.
    vecs.push_back(mk(0, 1, 0,   1, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0,   0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0,   0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0,   0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,   0, 0, 0, 0, 0, 1));
    // Second entry fills the lot.
    vecs.push_back(mk(0, 1, 0,   1, 0, 0, 1, 1, 2));
    vecs.push_back(mk(0, 0, 0,   0, 0, 0, 1, 1, 2));
    vecs.push_back(mk(0, 0, 0,   0, 0, 0, 1, 1, 2));
    vecs.push_back(mk(0, 0, 0,   0, 0, 0, 0, 1, 2));
    vecs.push_back(mk(0, 0, 0,   0, 0, 0, 0, 1, 2));
    // Entry while full: denied while held, count unchanged.
    vecs.push_back(mk(0, 1, 0,   0, 0, 1, 0, 1, 2));
    vecs.push_back(mk(0, 1, 0,   0, 0, 1, 0, 1, 2));
    vecs.push_back(mk(0, 0, 0,   0, 0, 0, 0, 1, 2));
    // Exit, released after ack.
    vecs.push_back(mk(0, 0, 1,   0, 1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0,   0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0,   0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0,   0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,   0, 0, 0, 0, 0, 1));
    // Exit held throughout: ignored while open, then denied at empty.
    vecs.push_back(mk(0, 0, 1,   0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1,   0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1,   0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1,   0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1,   0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1,   0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1,   0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,   0, 0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].ex);
      chk_all($sformatf("row%0d", i), vecs[i].ea, vecs[i].xa, vecs[i].dn,
              vecs[i].go, vecs[i].fu, int'(vecs[i].cnt));
    end

    // Tie: reach Count=1 with the last grant an exit, then hold both requests.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0); idle_cycles(4);
    step(1'b0, 1'b1, 1'b0); idle_cycles(4);
    step(1'b0, 1'b0, 1'b1); idle_cycles(4);
    chk("tie setup count", int'(Count), 1);
    ea_cyc = -1; xa_cyc = -1; ea_cnt = -1; xa_cnt = -1;
    for (int c = 1; c <= 20; c++) begin
      step(1'b0, 1'b1, 1'b1);
      if (Entry_Ack && ea_cyc < 0) begin ea_cyc = c; ea_cnt = int'(Count); end
      if (Exit_Ack && xa_cyc < 0) begin xa_cyc = c; xa_cnt = int'(Count); end
      if (xa_cyc >= 0) break;
    end
    chk("tie entry ack cycle", ea_cyc, 1);
    chk("tie entry count", ea_cnt, 2);
    chk("tie exit ack cycle", xa_cyc, 1 + OC + 2);
    chk("tie exit count", xa_cnt, 1);
    step(1'b0, 1'b0, 1'b0);

    // Reset in the middle of an open period.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk_all("rmo c1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    step(1'b0, 1'b0, 1'b0);
    chk_all("rmo c2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    step(1'b1, 1'b0, 1'b0);
    chk_all("rmo c3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    // Back in IDLE: a new entry is granted on the very next edge.
    step(1'b0, 1'b1, 1'b0);
    chk_all("rmo regrant", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    step(1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
